systolic_mem_responder: RTL

- Memory-side responder for the systolic controller's single-port memory interface. It serves the controller's `act_addr` / `mem_write` / `mem_data_write` requests and returns `mem_read`.
- It also arbitrates a host load/dump port against the array and issues the `new_data` launch pulse.
- It counts result writes into the C region and flags completion.
- It sits beside the systolic top and replaces the bench-level memory model.

---
 rtl/systolic_mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/systolic_mem_responder.sv
// Memory-side responder for the systolic controller: single-port word storage
// serving the array, a host load/dump port served only while idle, the
// new_data launch pulse, and a counter of result writes into the C region.
module systolic_mem_responder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned N      = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Array side
  input  logic [ADDR_W-1:0] act_addr,
  input  logic              mem_write,
  input  logic [WIDTH-1:0]  mem_data_write,
  output logic [WIDTH-1:0]  mem_read,
  // Host side
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic [WIDTH-1:0]  host_rdata,
  output logic              host_ack,
  // Run control
  input  logic              start,
  input  logic [3:0]        n,
  input  logic [ADDR_W-1:0] addr_C,
  output logic              new_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        wr_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // The counter must hold n*n for the largest n the 4-bit size input can carry.
  localparam int unsigned NMax  = (N > 15) ? N : 15;
  localparam int unsigned CntW  = $clog2(NMax * NMax + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        n_q;
  logic [ADDR_W-1:0] addr_c_q;
  logic              load_cfg;

  logic [CntW-1:0]   wr_count_q, wr_count_d;
  logic [CntW-1:0]   nn;
  logic [ADDR_W-1:0] c_offset;
  logic              in_region;

  logic              host_ack_q;
  logic              host_fire;
  logic              arr_we;

  logic [WIDTH-1:0]  mem [Depth];

  // Result-region size and membership; the subtraction wraps modulo 2**ADDR_W
  // so a region starting near the top of memory continues at address 0.
  assign nn        = CntW'(n_q) * CntW'(n_q);
  assign c_offset  = act_addr - addr_c_q;
  assign in_region = ({{CntW{1'b0}}, c_offset} < {{ADDR_W{1'b0}}, nn});

  // Host is served only in IDLE, loses to a same-cycle start, and must see one
  // cycle without ack before a held request is taken again.
  assign host_fire = (state_q == StIdle) && host_req && !start && !host_ack_q;

  // Array writes only land while the run is in progress.
  assign arr_we    = (state_q == StRun) && mem_write;

  assign host_ack  = host_ack_q;
  assign wr_count  = wr_count_q[7:0];

  // Next-state, counter update and state-decoded control outputs.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    load_cfg   = 1'b0;
    new_data   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_cfg = 1'b1;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        new_data   = 1'b1;
        busy       = 1'b1;
        wr_count_d = '0;
        state_d    = (n_q == 4'd0) ? StDone : StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (mem_write && in_region) begin
          wr_count_d = wr_count_q + CntW'(1);
        end
        // Leave on the same edge that records the final result write.
        if (wr_count_d == nn) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, latched run configuration and the result counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      addr_c_q   <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      if (load_cfg) begin
        n_q      <= n;
        addr_c_q <= addr_C;
      end
    end
  end

  // Storage write port; array and host writes are exclusive by state.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[act_addr] <= mem_data_write;
    end else if (host_fire && host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  // Registered read ports and host acknowledge; reads return pre-write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read   <= '0;
      host_rdata <= '0;
      host_ack_q <= 1'b0;
    end else begin
      mem_read   <= mem[act_addr];
      host_ack_q <= host_fire;
      if (host_fire && !host_we) begin
        host_rdata <= mem[host_addr];
      end
    end
  end

endmodule
